// File: rtl/scroll_l_seq.sv
`default_nettype none
// ============================================================================
//  Module   : scroll_l_seq
//  Purpose  : Display sequencer for four 7-segment "L" digits and a GPIO LED.
//             It takes the 1 Hz tick pulse and steps one of four patterns
//             (blink all, scroll left, scroll right, bounce). One pattern
//             step happens for every HOLD_TICKS accepted ticks.
//  Ports    : CLK   - system clock, rising edge
//             RST   - synchronous active-high reset
//             tick  - single-cycle pulse from the tick generator
//             run   - 1 = sequencing enabled, 0 = freeze all state
//             mode  - 0 blink, 1 scroll left, 2 scroll right, 3 bounce
//             en    - per-digit decoder enable (en[0] = rightmost digit)
//             led   - LED drive, toggles on every step
//             pos   - current lit-digit index (debug)
//             wrap  - one-cycle pulse when a pattern cycle completes
//  Revision : 1.0 - initial release
// ============================================================================
module scroll_l_seq #(
    parameter int HOLD_TICKS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick,
    input  logic       run,
    input  logic [1:0] mode,
    output logic [3:0] en,
    output logic       led,
    output logic [1:0] pos,
    output logic       wrap
);

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [1:0] c_MODE_BLINK  = 2'd0;
    localparam logic [1:0] c_MODE_LEFT   = 2'd1;
    localparam logic [1:0] c_MODE_RIGHT  = 2'd2;
    localparam logic [1:0] c_MODE_BOUNCE = 2'd3;
    localparam logic       c_DIR_UP      = 1'b0;
    localparam logic       c_DIR_DOWN    = 1'b1;

    logic [1:0] r_mode_q;
    logic [7:0] r_hold;
    logic       r_dir;
    logic       r_blink;
    logic [1:0] r_pos;
    logic [3:0] r_en;
    logic       r_led;
    logic       r_wrap;

    logic [1:0] w_mode_q_nxt;
    logic [7:0] w_hold_nxt;
    logic       w_dir_nxt;
    logic       w_blink_nxt;
    logic [1:0] w_pos_nxt;
    logic [3:0] w_en_nxt;
    logic       w_led_nxt;
    logic       w_wrap_nxt;

    logic       w_mode_chg;
    logic       w_accept;
    logic [1:0] w_pos_inc;
    logic [1:0] w_pos_dec;

    function automatic logic [3:0] onehot(input logic [1:0] p);
        onehot = 4'b0001 << p;
    endfunction

    // A mode change always wins over a tick in the same cycle.
    assign w_mode_chg = (mode != r_mode_q);
    assign w_accept   = tick & run & ~w_mode_chg;
    assign w_pos_inc  = r_pos + 2'd1;
    assign w_pos_dec  = r_pos - 2'd1;

    always_comb begin
        w_mode_q_nxt = r_mode_q;
        w_hold_nxt   = r_hold;
        w_dir_nxt    = r_dir;
        w_blink_nxt  = r_blink;
        w_pos_nxt    = r_pos;
        w_en_nxt     = r_en;
        w_led_nxt    = r_led;
        w_wrap_nxt   = 1'b0;

        if (w_mode_chg) begin
            w_mode_q_nxt = mode;
            w_hold_nxt   = 8'd0;
            w_dir_nxt    = c_DIR_UP;
            w_pos_nxt    = (mode == c_MODE_RIGHT) ? 2'd3 : 2'd0;
            if (mode == c_MODE_BLINK) begin
                w_blink_nxt = 1'b0;
                w_en_nxt    = 4'b0000;
            end else begin
                w_en_nxt    = onehot((mode == c_MODE_RIGHT) ? 2'd3 : 2'd0);
            end
        end else if (w_accept) begin
            if (r_hold == c_HOLD_LAST) begin
                w_hold_nxt = 8'd0;
                w_led_nxt  = ~r_led;
                case (r_mode_q)
                    c_MODE_BLINK: begin
                        w_blink_nxt = ~r_blink;
                        w_en_nxt    = {4{~r_blink}};
                        w_wrap_nxt  = r_blink;
                    end
                    c_MODE_LEFT: begin
                        w_pos_nxt  = w_pos_inc;
                        w_en_nxt   = onehot(w_pos_inc);
                        w_wrap_nxt = (r_pos == 2'd3);
                    end
                    c_MODE_RIGHT: begin
                        w_pos_nxt  = w_pos_dec;
                        w_en_nxt   = onehot(w_pos_dec);
                        w_wrap_nxt = (r_pos == 2'd0);
                    end
                    c_MODE_BOUNCE: begin
                        // Direction flips on arrival at either end so the
                        // end digits are lit for only one step each.
                        if (r_dir == c_DIR_UP) begin
                            w_pos_nxt = w_pos_inc;
                            w_en_nxt  = onehot(w_pos_inc);
                            if (w_pos_inc == 2'd3) begin
                                w_dir_nxt = c_DIR_DOWN;
                            end
                        end else begin
                            w_pos_nxt = w_pos_dec;
                            w_en_nxt  = onehot(w_pos_dec);
                            if (w_pos_dec == 2'd0) begin
                                w_dir_nxt  = c_DIR_UP;
                                w_wrap_nxt = 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_wrap_nxt = 1'b0;
                    end
                endcase
            end else begin
                w_hold_nxt = r_hold + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mode_q <= mode;
            r_hold   <= 8'd0;
            r_dir    <= c_DIR_UP;
            r_blink  <= 1'b0;
            r_pos    <= 2'd0;
            r_en     <= 4'b0000;
            r_led    <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_mode_q <= w_mode_q_nxt;
            r_hold   <= w_hold_nxt;
            r_dir    <= w_dir_nxt;
            r_blink  <= w_blink_nxt;
            r_pos    <= w_pos_nxt;
            r_en     <= w_en_nxt;
            r_led    <= w_led_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign en   = r_en;
    assign led  = r_led;
    assign pos  = r_pos;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scroll_l_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scroll_l_seq
//  Purpose  : Scoreboard bench for scroll_l_seq. The driver applies one input
//             set per cycle and pushes the expected registered outputs; a
//             monitor pops and compares after every rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scroll_l_seq;

    localparam int c_HOLD = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       tick;
    logic       run;
    logic [1:0] mode;
    logic [3:0] en;
    logic       led;
    logic [1:0] pos;
    logic       wrap;

    scroll_l_seq #(.HOLD_TICKS(c_HOLD)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick),
        .run  (run),
        .mode (mode),
        .en   (en),
        .led  (led),
        .pos  (pos),
        .wrap (wrap)
    );

    always #5 CLK = ~CLK;

    // Packed expectation: {en, led, pos, wrap}
    logic [7:0] exp_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         cyc       = 0;
    bit         done      = 1'b0;

    // Reference model state
    int m_mode_q = 0;
    int m_hold   = 0;
    int m_phase  = 0;
    int m_pos    = 0;
    int m_blink  = 0;
    int m_led    = 0;
    int m_en     = 0;
    int m_wrap   = 0;
    int bounce_seq[6] = '{0, 1, 2, 3, 2, 1};

    task automatic model_step(input int r, input int t, input int ru, input int m);
        m_wrap = 0;
        if (r != 0) begin
            m_mode_q = m; m_hold = 0; m_phase = 0; m_pos = 0;
            m_blink = 0; m_en = 0; m_led = 0;
        end else if (m != m_mode_q) begin
            m_mode_q = m; m_hold = 0; m_phase = 0;
            m_pos = (m == 2) ? 3 : 0;
            if (m == 0) begin
                m_blink = 0; m_en = 0;
            end else begin
                m_en = 1 << m_pos;
            end
        end else if (t != 0 && ru != 0) begin
            if (m_hold + 1 < c_HOLD) begin
                m_hold++;
            end else begin
                m_hold = 0;
                m_led  = 1 - m_led;
                case (m_mode_q)
                    0: begin
                        m_blink = 1 - m_blink;
                        m_en    = (m_blink != 0) ? 15 : 0;
                        m_wrap  = (m_blink == 0) ? 1 : 0;
                    end
                    1: begin
                        m_wrap = (m_pos == 3) ? 1 : 0;
                        m_pos  = (m_pos + 1) % 4;
                        m_en   = 1 << m_pos;
                    end
                    2: begin
                        m_wrap = (m_pos == 0) ? 1 : 0;
                        m_pos  = (m_pos + 3) % 4;
                        m_en   = 1 << m_pos;
                    end
                    default: begin
                        m_phase = (m_phase + 1) % 6;
                        m_pos   = bounce_seq[m_phase];
                        m_wrap  = (m_phase == 0) ? 1 : 0;
                        m_en    = 1 << m_pos;
                    end
                endcase
            end
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic ru, input logic [1:0] m);
        logic [7:0] e;
        RST  = r;
        tick = t;
        run  = ru;
        mode = m;
        model_step(int'(r), int'(t), int'(ru), int'(m));
        e = {m_en[3:0], m_led[0], m_pos[1:0], m_wrap[0]};
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    // Monitor: one output observation per rising edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (!done) begin
                cyc++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL outputs cyc=%0d: no expectation queued (scoreboard underflow)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({en, led, pos, wrap} === e) begin
                        pass_cnt++;
                    end else begin
                        $display("FAIL outputs cyc=%0d: got en=%b led=%b pos=%0d wrap=%b, expected en=%b led=%b pos=%0d wrap=%b",
                                 cyc, en, led, pos, wrap, e[7:4], e[3], e[2:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset, blink all
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        // Scroll left, ticks with gaps
        drive(0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 1);
            drive(0, 0, 1, 1);
        end
        // Frozen: ticks ignored
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 1);
        // Scroll right
        drive(0, 0, 1, 2);
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 2);
        // Tick coinciding with a mode change, then bounce
        drive(0, 1, 1, 1);
        drive(0, 1, 1, 3);
        for (int i = 0; i < 16; i++) drive(0, 1, 1, 3);
        drive(0, 1, 1, 3);
        // Reset mid-bounce
        drive(1, 1, 1, 3);
        drive(0, 0, 1, 3);
        for (int i = 0; i < 6; i++) drive(0, 1, 1, 3);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic       r;
            logic       t;
            logic       ru;
            logic [1:0] m;
            r  = ($urandom_range(0, 99) == 0);
            t  = ($urandom_range(0, 2) != 0);
            ru = ($urandom_range(0, 7) != 0);
            m  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : mode;
            drive(r, t, ru, m);
        end
        drive(0, 0, 1, mode);
        done = 1'b1;
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Absolute time bound in case the clock or driver stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
